// File: rtl/serv_ext_sched.sv
// Purpose : dispatch SERV extension-port requests to the MDU (unit 0) or FPU (unit 1).
// Latency : legal select 3+N cycles from accept to o_ext_ready (N = unit delay after ISSUE); illegal select 1 cycle.
// Backpressure: one request in flight; a unit valid is held until that unit's ready pulse or TIMEOUT.
//
// Ports:
//   clk, i_rst_n                    - clock, asynchronous active-low reset
//   i_ext_* / o_ext_*               - core side: valid held until the one-cycle o_ext_ready pulse
//   o_mdu_valid / o_fpu_valid       - per-unit request, held until the matching i_*_ready
//   o_unit_funct3/rs1/rs2           - latched operands, shared by both units
//   i_mdu_ready/rd, i_fpu_ready/rd  - unit completion pulse and result
//   o_busy                          - high whenever the scheduler is not IDLE
module serv_ext_sched #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_ext_valid,
  input  logic [1:0]  i_ext_sel,
  input  logic [2:0]  i_ext_funct3,
  input  logic [31:0] i_ext_rs1,
  input  logic [31:0] i_ext_rs2,
  output logic        o_ext_ready,
  output logic [31:0] o_ext_rd,
  output logic        o_ext_err,
  output logic        o_mdu_valid,
  output logic        o_fpu_valid,
  output logic [2:0]  o_unit_funct3,
  output logic [31:0] o_unit_rs1,
  output logic [31:0] o_unit_rs2,
  input  logic        i_mdu_ready,
  input  logic [31:0] i_mdu_rd,
  input  logic        i_fpu_ready,
  input  logic [31:0] i_fpu_rd,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            unit_q, unit_d;      // 0 = MDU, 1 = FPU
  logic            skip_q, skip_d;      // blocks re-sampling the stale request right after RESP
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mdu_vld_q, mdu_vld_d;
  logic            fpu_vld_q, fpu_vld_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [31:0]     rs1_q, rs1_d;
  logic [31:0]     rs2_q, rs2_d;
  logic [31:0]     rd_q, rd_d;
  logic            err_q, err_d;
  logic            rdy_q, rdy_d;

  logic            unit_rdy;
  logic [31:0]     unit_rd;

  // Only the selected unit's handshake is observed; the other one is cross-talk.
  assign unit_rdy = unit_q ? i_fpu_ready : i_mdu_ready;
  assign unit_rd  = unit_q ? i_fpu_rd    : i_mdu_rd;

  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    skip_d    = skip_q;
    cnt_d     = cnt_q;
    mdu_vld_d = mdu_vld_q;
    fpu_vld_d = fpu_vld_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    err_d     = err_q;
    rdy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        skip_d = 1'b0;
        if (i_ext_valid && !skip_q) begin
          funct3_d = i_ext_funct3;
          rs1_d    = i_ext_rs1;
          rs2_d    = i_ext_rs2;
          unit_d   = i_ext_sel[0];
          if (i_ext_sel[1]) begin
            // Illegal select: answer directly with an error, no unit involved.
            state_d = RESP;
            rdy_d   = 1'b1;
            err_d   = 1'b1;
            rd_d    = '0;
          end else begin
            state_d   = ISSUE;
            mdu_vld_d = !i_ext_sel[0];
            fpu_vld_d = i_ext_sel[0];
          end
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // Ready is checked first so a completion on the timeout cycle still succeeds.
        if (unit_rdy) begin
          rd_d      = unit_rd;
          err_d     = 1'b0;
          rdy_d     = 1'b1;
          mdu_vld_d = 1'b0;
          fpu_vld_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == TO_LAST) begin
          rd_d      = '1;
          err_d     = 1'b1;
          rdy_d     = 1'b1;
          mdu_vld_d = 1'b0;
          fpu_vld_d = 1'b0;
          state_d   = RESP;
        end
      end

      RESP: begin
        // Result is only visible during the ready pulse.
        rd_d    = '0;
        err_d   = 1'b0;
        skip_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      unit_q    <= 1'b0;
      skip_q    <= 1'b0;
      cnt_q     <= '0;
      mdu_vld_q <= 1'b0;
      fpu_vld_q <= 1'b0;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      skip_q    <= skip_d;
      cnt_q     <= cnt_d;
      mdu_vld_q <= mdu_vld_d;
      fpu_vld_q <= fpu_vld_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
    end
  end

  assign o_ext_ready   = rdy_q;
  assign o_ext_rd      = rd_q;
  assign o_ext_err     = err_q;
  assign o_mdu_valid   = mdu_vld_q;
  assign o_fpu_valid   = fpu_vld_q;
  assign o_unit_funct3 = funct3_q;
  assign o_unit_rs1    = rs1_q;
  assign o_unit_rs2    = rs2_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serv_ext_sched.sv
// Purpose : directed, table-driven check of serv_ext_sched against hand-computed results.
// Latency : lat is counted in clock edges from the accept edge to the edge sampling o_ext_ready.
// Backpressure: the bench plays the core (holds valid until ready) and both extension units.
module tb_serv_ext_sched;

  logic        clk;
  logic        i_rst_n;
  logic        i_ext_valid;
  logic [1:0]  i_ext_sel;
  logic [2:0]  i_ext_funct3;
  logic [31:0] i_ext_rs1;
  logic [31:0] i_ext_rs2;
  logic        o_ext_ready;
  logic [31:0] o_ext_rd;
  logic        o_ext_err;
  logic        o_mdu_valid;
  logic        o_fpu_valid;
  logic [2:0]  o_unit_funct3;
  logic [31:0] o_unit_rs1;
  logic [31:0] o_unit_rs2;
  logic        i_mdu_ready;
  logic [31:0] i_mdu_rd;
  logic        i_fpu_ready;
  logic [31:0] i_fpu_rd;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  serv_ext_sched #(.TIMEOUT(64), .TO_W(16)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_ext_valid  (i_ext_valid),
    .i_ext_sel    (i_ext_sel),
    .i_ext_funct3 (i_ext_funct3),
    .i_ext_rs1    (i_ext_rs1),
    .i_ext_rs2    (i_ext_rs2),
    .o_ext_ready  (o_ext_ready),
    .o_ext_rd     (o_ext_rd),
    .o_ext_err    (o_ext_err),
    .o_mdu_valid  (o_mdu_valid),
    .o_fpu_valid  (o_fpu_valid),
    .o_unit_funct3(o_unit_funct3),
    .o_unit_rs1   (o_unit_rs1),
    .o_unit_rs2   (o_unit_rs2),
    .i_mdu_ready  (i_mdu_ready),
    .i_mdu_rd     (i_mdu_rd),
    .i_fpu_ready  (i_fpu_ready),
    .i_fpu_rd     (i_fpu_rd),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One directed transaction: request fields, unit behaviour, expected outcome.
  // delay = valid-high cycles before the unit raises ready (-1 = never),
  // xtalk = valid-high cycle on which the other unit pulses a spurious ready (0 = none).
  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] urd;
    int          delay;
    int          xtalk;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_mvc;
    int          exp_fvc;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int          mvc, fvc, vcnt, pulses, seen;
    logic [31:0] rd;
    logic        err, busy_resp, sel_vld;
    mvc = 0; fvc = 0; vcnt = 0; pulses = 0; seen = -1;
    rd = '0; err = 1'b0; busy_resp = 1'b0;
    i_ext_valid  = 1'b1;
    i_ext_sel    = v.sel;
    i_ext_funct3 = v.f3;
    i_ext_rs1    = v.rs1;
    i_ext_rs2    = v.rs2;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_mdu_valid) mvc++;
      if (o_fpu_valid) fvc++;
      sel_vld = v.sel[0] ? o_fpu_valid : o_mdu_valid;
      if (sel_vld) vcnt++;
      if (o_ext_ready) begin
        pulses++;
        if (seen < 0) begin
          seen      = i;
          rd        = o_ext_rd;
          err       = o_ext_err;
          busy_resp = o_busy;
        end
      end
      @(posedge clk);
      #1;
      // Operand changes after the accept edge must not reach the units.
      if (i == 0) begin
        i_ext_rs1    = ~v.rs1;
        i_ext_rs2    = ~v.rs2;
        i_ext_funct3 = ~v.f3;
      end
      if (seen >= 0) i_ext_valid = 1'b0;
      i_mdu_ready = 1'b0;
      i_fpu_ready = 1'b0;
      if (v.delay > 0 && sel_vld && vcnt == v.delay) begin
        if (v.sel[0]) begin i_fpu_ready = 1'b1; i_fpu_rd = v.urd; end
        else          begin i_mdu_ready = 1'b1; i_mdu_rd = v.urd; end
      end
      if (v.xtalk > 0 && sel_vld && vcnt == v.xtalk) begin
        if (v.sel[0]) begin i_mdu_ready = 1'b1; i_mdu_rd = 32'h0BADBAD0; end
        else          begin i_fpu_ready = 1'b1; i_fpu_rd = 32'h0BADBAD0; end
      end
      if (seen >= 0 && i >= seen + 2) break;
    end
    i_ext_valid = 1'b0;
    chk({nm, ".lat"},    64'(seen),    64'(v.exp_lat));
    chk({nm, ".rd"},     64'(rd),      64'(v.exp_rd));
    chk({nm, ".err"},    64'(err),     64'(v.exp_err));
    chk({nm, ".pulses"}, 64'(pulses),  64'd1);
    chk({nm, ".mdu_vld_cycles"}, 64'(mvc), 64'(v.exp_mvc));
    chk({nm, ".fpu_vld_cycles"}, 64'(fvc), 64'(v.exp_fvc));
    chk({nm, ".busy_in_resp"},   64'(busy_resp), 64'd1);
    chk({nm, ".operands"}, {o_unit_rs1, o_unit_rs2}, {v.rs1, v.rs2});
    chk({nm, ".funct3"},   64'(o_unit_funct3), 64'(v.f3));
  endtask

  initial begin
    logic  seen_rdy;
    int    waited;

    //          sel  f3      rs1           rs2           urd           dly xt  exp_rd        err lat mvc fvc
    tbl[0] = '{2'd0, 3'b000, 32'd7,        32'd6,        32'd42,       5,  0, 32'd42,        1'b0, 7,  6,  0};
    tbl[1] = '{2'd1, 3'b001, 32'h3F800000, 32'h40000000, 32'h40400000, 2,  0, 32'h40400000, 1'b0, 4,  0,  3};
    tbl[2] = '{2'd2, 3'b101, 32'hAAAA0000, 32'h00005555, 32'd0,        -1, 0, 32'd0,         1'b1, 1,  0,  0};
    tbl[3] = '{2'd3, 3'b111, 32'd1,        32'd2,        32'd0,        -1, 0, 32'd0,         1'b1, 1,  0,  0};
    tbl[4] = '{2'd1, 3'b010, 32'd10,       32'd20,       32'h00001234, 4,  2, 32'h00001234, 1'b0, 6,  0,  5};
    tbl[5] = '{2'd1, 3'b011, 32'd5,        32'd6,        32'h000055AA, 64, 0, 32'h000055AA, 1'b0, 66, 0,  65};
    tbl[6] = '{2'd0, 3'b100, 32'd8,        32'd9,        32'd0,        -1, 0, 32'hFFFFFFFF, 1'b1, 66, 65, 0};
    tbl[7] = '{2'd0, 3'b110, 32'd11,       32'd12,       32'd99,       1,  0, 32'd99,        1'b0, 3,  2,  0};

    i_rst_n      = 1'b0;
    i_ext_valid  = 1'b0;
    i_ext_sel    = '0;
    i_ext_funct3 = '0;
    i_ext_rs1    = '0;
    i_ext_rs2    = '0;
    i_mdu_ready  = 1'b0;
    i_mdu_rd     = '0;
    i_fpu_ready  = 1'b0;
    i_fpu_rd     = '0;

    #3;
    chk("reset.ctrl", 64'({o_mdu_valid, o_fpu_valid, o_ext_ready, o_ext_err, o_busy, o_unit_funct3}), 64'd0);
    chk("reset.data", {o_unit_rs1 | o_ext_rd, o_unit_rs2}, 64'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_txn(tbl[t], $sformatf("vec%0d", t));
      if (t == 6) begin
        // Late MDU ready after the timeout: must not produce a response.
        seen_rdy = 1'b0;
        i_mdu_ready = 1'b1;
        i_mdu_rd    = 32'hDEADBEEF;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (o_ext_ready || o_busy) seen_rdy = 1'b1;
          @(posedge clk);
          #1;
          i_mdu_ready = 1'b0;
        end
        chk("late_ready.ignored", 64'(seen_rdy), 64'd0);
      end
    end

    // Reset asserted while the FPU request is outstanding.
    i_ext_valid  = 1'b1;
    i_ext_sel    = 2'd1;
    i_ext_funct3 = 3'b011;
    i_ext_rs1    = 32'h12345678;
    i_ext_rs2    = 32'h9ABCDEF0;
    waited = 0;
    while (!o_fpu_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_mid.fpu_valid_seen", 64'(o_fpu_valid), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    i_rst_n     = 1'b0;
    i_ext_valid = 1'b0;
    #1;
    chk("rst_mid.ctrl", 64'({o_mdu_valid, o_fpu_valid, o_ext_ready, o_ext_err, o_busy, o_unit_funct3}), 64'd0);
    chk("rst_mid.data", {o_unit_rs1 | o_ext_rd, o_unit_rs2}, 64'd0);
    seen_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_ext_ready) seen_rdy = 1'b1;
    end
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (o_ext_ready) seen_rdy = 1'b1;
    end
    chk("rst_mid.no_response", 64'(seen_rdy), 64'd0);
    @(posedge clk);
    #1;
    run_txn('{2'd0, 3'b001, 32'd3, 32'd4, 32'd77, 3, 0, 32'd77, 1'b0, 5, 4, 0}, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_ext_sched.md
Name: serv_ext_sched

Overview:
Dispatcher between the SERV core's single extension port (valid/ready, rs1/rs2/funct3/rd) and two bit-parallel extension units: MDU (unit 0) and FPU (unit 1).
- Latches the operands once per request and routes the request to the selected unit.
- Holds the unit handshake until the unit completes.
- Registers the result and returns a one-cycle ready pulse to the core.
- Guards against hung units with a timeout, and against illegal unit selects.

Parameters:
TIMEOUT, 64, max cycles waiting for unit ready before forced error completion; legal range 2..65535.
TO_W, 16, width of timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_ext_valid  input  1  core request; held high until o_ext_ready pulse
i_ext_sel  input  2  unit select: 0=MDU, 1=FPU, 2/3 illegal
i_ext_funct3  input  3  operation funct3 from decoder
i_ext_rs1  input  32  operand A
i_ext_rs2  input  32  operand B
o_ext_ready  output  1  one-cycle completion pulse to core
o_ext_rd  output  32  result; valid while o_ext_ready=1, else 0
o_ext_err  output  1  qualified by o_ext_ready; 1 = timeout or illegal select
o_mdu_valid  output  1  request to MDU, held until i_mdu_ready
o_fpu_valid  output  1  request to FPU, held until i_fpu_ready
o_unit_funct3  output  3  latched funct3, shared to both units
o_unit_rs1  output  32  latched rs1, shared
o_unit_rs2  output  32  latched rs2, shared
i_mdu_ready  input  1  MDU completion pulse
i_mdu_rd  input  32  MDU result, valid with i_mdu_ready
i_fpu_ready  input  1  FPU completion pulse
i_fpu_rd  input  32  FPU result, valid with i_fpu_ready
o_busy  output  1  high in any state other than IDLE

Behaviour:
Reset (async, i_rst_n=0):
- State=IDLE; all outputs 0, including latched operands and the timeout counter.

States: IDLE, ISSUE, WAIT, RESP.

IDLE:
- If i_ext_valid=1, latch sel/funct3/rs1/rs2.
- If sel<=1, go to ISSUE; if sel>=2, go to RESP with err=1, rd=0.

ISSUE (one cycle):
- Assert the selected unit valid (o_mdu_valid or o_fpu_valid); the other unit's valid stays 0.
- Clear the timeout counter; go to WAIT.

WAIT:
- Unit valid stays high. Counter increments each cycle.
- Selected unit ready=1: capture its rd, err=0, drop valid, go to RESP.
- Ready from the non-selected unit is ignored.
- Counter reaching TIMEOUT-1 with no ready: rd=32'hFFFFFFFF, err=1, drop valid, go to RESP.
- Ready and timeout in the same cycle: ready wins, err=0.

RESP (one cycle):
- o_ext_ready=1, o_ext_rd and o_ext_err driven from registers; go to IDLE.

Request handling:
- A new request is not sampled in the cycle after RESP, because i_ext_valid from the core is still deasserting. IDLE requires i_ext_valid to be sampled while o_ext_ready=0, so minimum issue spacing is 1 idle cycle.
- Latency, request-accept edge to o_ext_ready: 3 + N cycles, where N is the unit ready delay after ISSUE. Illegal select: o_ext_ready 1 cycle after accept.
- Operand outputs are stable from ISSUE until the next accept. Changes on i_ext_rs* after accept are ignored.

Reset and timeout:
- Reset asserted mid-operation drops unit valid immediately (async); no response is issued.
- A late unit ready arriving after a timeout, while in IDLE/RESP, is ignored. It does not corrupt the next transaction's result, because only WAIT captures.

Test Plan:
- MDU op: sel=0, funct3=3'b000, rs1=7, rs2=6; MDU ready 5 cycles after valid with rd=42 -> o_mdu_valid high exactly 6 cycles, o_fpu_valid stays 0, o_ext_ready single pulse with rd=42, err=0.
- FPU op: sel=1, rs1=32'h3F800000, rs2=32'h40000000; FPU ready 2 cycles later with rd=32'h40400000 -> o_ext_rd=32'h40400000, err=0, o_unit_funct3 equals the latched value.
- Illegal select: sel=2 -> no unit valid asserted; o_ext_ready 1 cycle after accept with rd=0, err=1.
- Timeout: sel=0, MDU never ready, TIMEOUT=64 -> o_mdu_valid drops after 64 WAIT cycles; o_ext_ready with rd=32'hFFFFFFFF, err=1. A late MDU ready 3 cycles later is ignored, and the next request completes normally.
- Cross-talk and boundary: FPU request with spurious i_mdu_ready pulse during WAIT -> ignored, result from FPU. FPU ready on the exact timeout cycle -> err=0, FPU rd returned.
- Reset mid-WAIT: drop i_rst_n while o_fpu_valid=1 -> all outputs 0 immediately, no o_ext_ready. After release, a new MDU request completes correctly.
